// File: rtl/mem_access_unit.sv
// Requester side of the data port of the dual-port word memory: one load/store at a time,
// load extension, and read-modify-write for byte/half stores against the whole-word write port.
module mem_access_unit #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (RD_LATENCY > 32'sd2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        CNT_W'((RD_LATENCY >= 32'sd2) ? (RD_LATENCY - 32'sd2) : 32'sd0);
    localparam bit NO_WAIT = (RD_LATENCY == 32'sd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DATA  = 3'd3,
        WR       = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [1:0]        lane_r, lane_s;
    logic [1:0]        size_r, size_s;
    logic              unsigned_r, unsigned_s;
    logic              write_r, write_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              ready_r, ready_s;
    logic              resp_valid_r, resp_valid_s;
    logic [DATA_W-1:0] resp_rdata_r, resp_rdata_s;
    logic              misaligned_r, misaligned_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              mem_we_r, mem_we_s;

    // Address bits above the word-address range wrap away by design.
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^req_addr[31:ADDR_W+2];

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lane,
                                                      input logic              is_unsigned);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00: begin
                if (is_unsigned) begin
                    res = {{(DATA_W-8){1'b0}}, b};
                end else begin
                    res = {{(DATA_W-8){b[7]}}, b};
                end
            end
            2'b01: begin
                if (is_unsigned) begin
                    res = {{(DATA_W-16){1'b0}}, h};
                end else begin
                    res = {{(DATA_W-16){h[15]}}, h};
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lane);
        logic [DATA_W-1:0] res;
        res = old_word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Next-state and next-output logic; single-cycle pulses default low every cycle.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        lane_s       = lane_r;
        size_s       = size_r;
        unsigned_s   = unsigned_r;
        write_s      = write_r;
        wdata_s      = wdata_r;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata_r;
        misaligned_s = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        misaligned_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        lane_s     = req_addr[1:0];
                        size_s     = req_size;
                        unsigned_s = req_unsigned;
                        write_s    = req_write;
                        wdata_s    = req_wdata;
                        mem_addr_s = req_addr[ADDR_W+1:2];
                        // A whole-word store needs no read: go straight to the write.
                        if (req_write && req_size[1]) begin
                            mem_wdata_s = req_wdata;
                            mem_we_s    = 1'b1;
                            state_s     = WR;
                        end else begin
                            state_s = RD_ISSUE;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ISSUE: begin
                cnt_s = WAIT_INIT;
                if (NO_WAIT) begin
                    state_s = RD_DATA;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = RD_DATA;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RD_DATA: begin
                if (write_r) begin
                    mem_wdata_s = merge_store(mem_rdata, wdata_r, size_r, lane_r);
                    mem_we_s    = 1'b1;
                    state_s     = WR;
                end else begin
                    resp_valid_s = 1'b1;
                    resp_rdata_s = extend_load(mem_rdata, size_r, lane_r, unsigned_r);
                    state_s      = IDLE;
                end
            end
            WR: begin
                resp_valid_s = 1'b1;
                state_s      = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latches, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r        <= CNT_ZERO;
            lane_r       <= 2'b00;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            write_r      <= 1'b0;
            wdata_r      <= '0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            misaligned_r <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_we_r     <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            lane_r       <= lane_s;
            size_r       <= size_s;
            unsigned_r   <= unsigned_s;
            write_r      <= write_s;
            wdata_r      <= wdata_s;
            ready_r      <= ready_s;
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            misaligned_r <= misaligned_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_we_r     <= mem_we_s;
        end
    end

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign misaligned = misaligned_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a word memory with 2-cycle read latency, a
// transaction-level reference model, and a per-cycle compare process.
module tb_mem_access_unit;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, misaligned, mem_we;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(14), .DATA_W(32), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Memory port b: address registered at the edge, data usable two edges later.
    bit [31:0] tb_mem [16384];
    bit [31:0] ref_mem [16384];
    bit [31:0] pipe1, pipe2;
    always @(posedge clk) begin
        if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;
        pipe1 <= (mem_we === 1'b1) ? mem_wdata : tb_mem[mem_addr];
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Expectations of the single outstanding transaction, as absolute cycle numbers.
    int exp_resp, exp_we, exp_mis, exp_rd, free_cyc, last_e0;
    bit exp_is_load;
    logic [31:0] exp_rdata, exp_wdata, saved_word;
    logic [13:0] exp_maddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h cyc=%0d", nm, act, expv, cyc);
        end
    endtask

    task automatic clear_exp();
        exp_resp = -1; exp_we = -1; exp_mis = -1; exp_rd = -1; exp_is_load = 1'b0;
    endtask

    function automatic logic [31:0] load_val(logic [31:0] wd, logic [1:0] sz, logic [1:0] lane, logic u);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (wd >> (8 * lane)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (wd >> (16 * lane[1])) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = wd;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_val(logic [31:0] old, logic [31:0] d, logic [1:0] sz, logic [1:0] lane);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * lane; mask = 32'hFF << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * lane[1]; mask = 32'hFFFF << sh;
        end else begin
            sh = 0; mask = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // Transaction model: what must happen, in which cycle after the accepting edge.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input int c);
        int wi;
        bit mis;
        wi  = int'(a[15:2]);
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        clear_exp();
        last_e0   = c;
        exp_maddr = a[15:2];
        if (mis) begin
            exp_mis = c + 1; free_cyc = c + 1;
        end else if (!w) begin
            exp_rd = c + 1; exp_resp = c + L + 2; exp_is_load = 1'b1;
            exp_rdata = load_val(ref_mem[wi], sz, a[1:0], u);
            free_cyc = c + L + 2;
        end else if (sz[1]) begin
            exp_we = c + 1; exp_wdata = d; exp_resp = c + 2; free_cyc = c + 2;
            saved_word = ref_mem[wi]; ref_mem[wi] = d;
        end else begin
            exp_rd = c + 1; exp_we = c + L + 2; exp_resp = c + L + 3; free_cyc = c + L + 3;
            exp_wdata = store_val(ref_mem[wi], d, sz, a[1:0]);
            saved_word = ref_mem[wi]; ref_mem[wi] = exp_wdata;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(cyc >= free_cyc));
            chk("resp_valid", 32'(resp_valid), 32'(cyc == exp_resp));
            chk("misaligned", 32'(misaligned), 32'(cyc == exp_mis));
            chk("mem_we", 32'(mem_we), 32'(cyc == exp_we));
            if (cyc == exp_resp && exp_is_load) chk("resp_rdata", resp_rdata, exp_rdata);
            if (cyc == exp_we) begin
                chk("we_addr", 32'(mem_addr), 32'(exp_maddr));
                chk("we_data", mem_wdata, exp_wdata);
            end
            if (cyc == exp_rd) chk("rd_addr", 32'(mem_addr), 32'(exp_maddr));
        end
    end

    // Waits for the unit to be free (pulsing ignored junk requests meanwhile), then issues.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (cyc < free_cyc && n < 50) begin
            req_valid    = ($urandom_range(0, 3) == 0);
            req_write    = 1'($urandom);
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom);
            req_addr     = $urandom;
            req_wdata    = $urandom;
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL issue_timeout: waited=%0d limit=50", n);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        model(w, sz, u, a, d, cyc);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: cyc=%0d limit reached", cyc);
        $fatal(1);
    end

    initial begin
        int wecnt;
        bit [31:0] v;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        free_cyc = 0; clear_exp();
        for (int i = 0; i < 16; i++) begin
            v = $urandom; tb_mem[i] <= v; ref_mem[i] = v;
        end

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        #1 rst_n = 1'b1; free_cyc = cyc; chk_en = 1'b1;

        // Word store: write in cycle 1, response in cycle 2.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_we", 32'(mem_we), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'h004);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_resp", 32'(resp_valid), 32'd1);
        chk("t2_we_off", 32'(mem_we), 32'd0);

        // Loads with extension.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_1234);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("t3_model_lb", exp_rdata, 32'hFFFF_FF80);
        repeat (4) @(negedge clk);
        chk("t3_lb_valid", 32'(resp_valid), 32'd1);
        chk("t3_lb", resp_rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        repeat (4) @(negedge clk);
        chk("t3_lbu", resp_rdata, 32'h0000_0080);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        repeat (4) @(negedge clk);
        chk("t3_lh", resp_rdata, 32'hFFFF_80FF);

        // Byte store as read-modify-write.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB);
        wecnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) wecnt++;
            if (k == 4) chk("t4_wdata", mem_wdata, 32'hDEAD_ABEF);
            if (k == 5) chk("t4_resp", 32'(resp_valid), 32'd1);
        end
        chk("t4_we_count", 32'(wecnt), 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        repeat (4) @(negedge clk);
        chk("t4_lw", resp_rdata, 32'hDEAD_ABEF);

        // Misaligned word load.
        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        @(negedge clk);
        chk("t5_mis", 32'(misaligned), 32'd1);
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during a half store, with ignored requests while busy.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h5A5A);
        #1 req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0;
        @(negedge clk); #1 req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4;
        @(negedge clk); #1 req_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        clear_exp();
        ref_mem[8] = saved_word;
        free_cyc = last_e0 + 4;
        @(negedge clk);
        chk("t6_rdata_rst", resp_rdata, 32'd0);
        chk("t6_we", 32'(mem_we), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_mem", tb_mem[8], 32'h1122_3344);

        // Randomized traffic, including wrapped addresses.
        for (int t = 0; t < 300; t++) begin
            a = $urandom & 32'h0000_003F;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_0000);
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
        end
        for (int n = 0; n < 20 && cyc < free_cyc; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
